// File: rtl/crop_roi_sequencer_pkg.sv
// Shared types, default geometry and clamp-limit helpers for the crop ROI sequencer.
package crop_ctl_pkg;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Largest legal top-left corner; X is one lower because the filter keeps x in (X1, X1+OUT_COLS].
  function automatic int roi_y_max(input int in_rows, input int out_rows);
    return in_rows - out_rows;
  endfunction

  function automatic int roi_x_max(input int in_cols, input int out_cols);
    return in_cols - out_cols - 1;
  endfunction

  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_IN_ROWS  = 40;
  localparam int DEF_IN_COLS  = 40;
  localparam int DEF_OUT_ROWS = 20;
  localparam int DEF_OUT_COLS = 20;
  localparam int RW           = 10;
  localparam int CW           = 10;
  localparam int FRAME_PIX    = DEF_IN_ROWS * DEF_IN_COLS;
  localparam int PIXCNT_W     = $clog2(FRAME_PIX);
  localparam int REQ_ID_W     = id_width(DEF_NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_e;

endpackage

// File: rtl/crop_roi_sequencer_rr_arbiter.sv
// Round-robin pick among N requesters; the pointer advances past the winner on accept.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;

  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr_q) + k) % N]) begin
        found    = 1'b1;
        grant_id = IDW'((int'(ptr_q) + k) % N);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = found && (grant_id == IDW'(gi));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/crop_roi_sequencer.sv
// Frame-level controller for crop_filter: grants one ROI per frame, loads Y1/X1,
// gates one frame of pixels, then pulses the filter reset.
module crop_roi_sequencer
  import crop_ctl_pkg::*;
#(
  parameter int NUM_REQ          = DEF_NUM_REQ,
  parameter int IN_ROWS          = DEF_IN_ROWS,
  parameter int IN_COLS          = DEF_IN_COLS,
  parameter int OUT_ROWS         = DEF_OUT_ROWS,
  parameter int OUT_COLS         = DEF_OUT_COLS,
  parameter int IMG_ROW_BITWIDTH = RW,
  parameter int IMG_COL_BITWIDTH = CW
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_REQ*(IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH)-1:0] req_roi_TDATA,
  input  logic [NUM_REQ-1:0]                                     req_roi_TVALID,
  output logic [NUM_REQ-1:0]                                     req_roi_TREADY,
  input  logic                                                   up_pix_TVALID,
  output logic                                                   up_pix_TREADY,
  output logic                                                   flt_pix_TVALID,
  input  logic                                                   flt_pix_TREADY,
  output logic [IMG_ROW_BITWIDTH-1:0]                            crop_Y1_TDATA,
  output logic                                                   crop_Y1_TVALID,
  input  logic                                                   crop_Y1_TREADY,
  output logic [IMG_COL_BITWIDTH-1:0]                            crop_X1_TDATA,
  output logic                                                   crop_X1_TVALID,
  input  logic                                                   crop_X1_TREADY,
  output logic                                                   flt_reset,
  output logic                                                   frame_done,
  output logic [id_width(NUM_REQ)-1:0]                           frame_req_id,
  output logic                                                   roi_clamped,
  output logic                                                   busy
);

  localparam int YW    = IMG_ROW_BITWIDTH;
  localparam int XW    = IMG_COL_BITWIDTH;
  localparam int DW    = YW + XW;
  localparam int MW    = ((YW > XW) ? YW : XW) + 1;
  localparam int NPIX  = IN_ROWS * IN_COLS;
  localparam int CNT_W = $clog2(NPIX);
  localparam int IDW   = id_width(NUM_REQ);

  localparam logic [MW-1:0]    Y_LIM    = MW'(roi_y_max(IN_ROWS, OUT_ROWS));
  localparam logic [MW-1:0]    X_LIM    = MW'(roi_x_max(IN_COLS, OUT_COLS));
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

  state_e             state_q, state_d;
  logic [YW-1:0]      y1_q, y1_d;
  logic [XW-1:0]      x1_q, x1_d;
  logic               y1_vld_q, y1_vld_d;
  logic               x1_vld_q, x1_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               flush_q, flush_d;
  logic               clamped_q, clamped_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic [DW-1:0]      req_word [NUM_REQ];
  logic [DW-1:0]      win_word;
  logic [YW-1:0]      y_raw;
  logic [XW-1:0]      x_raw;
  logic               y_over, x_over;
  logic               in_idle, in_run, req_hs, pix_hs;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_roi_TDATA[gi*DW +: DW];
  end

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_roi_TVALID),
    .advance  (req_hs),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Gates are also closed while reset is held so nothing handshakes during a flush-by-reset.
  assign in_idle = (state_q == IDLE) && !reset;
  assign in_run  = (state_q == RUN) && !reset;
  assign req_roi_TREADY = in_idle ? grant : '0;
  assign req_hs  = in_idle && (|grant);
  assign pix_hs  = in_run && up_pix_TVALID && flt_pix_TREADY;

  assign win_word = req_word[grant_id];
  assign y_raw    = win_word[DW-1:XW];
  assign x_raw    = win_word[XW-1:0];
  assign y_over   = MW'(y_raw) > Y_LIM;
  assign x_over   = MW'(x_raw) > X_LIM;

  always_comb begin
    state_d   = state_q;
    y1_d      = y1_q;
    x1_d      = x1_q;
    y1_vld_d  = y1_vld_q;
    x1_vld_d  = x1_vld_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    flush_d   = 1'b0;
    clamped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          y1_d      = y_over ? YW'(Y_LIM) : y_raw;
          x1_d      = x_over ? XW'(X_LIM) : x_raw;
          id_d      = grant_id;
          clamped_d = y_over || x_over;
          y1_vld_d  = 1'b1;
          x1_vld_d  = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (y1_vld_q && crop_Y1_TREADY) y1_vld_d = 1'b0;
        if (x1_vld_q && crop_X1_TREADY) x1_vld_d = 1'b0;
        if (!y1_vld_d && !x1_vld_d) state_d = RUN;
      end
      RUN: begin
        if (pix_hs) begin
          if (cnt_q == LAST_PIX) begin
            cnt_d   = '0;
            flush_d = 1'b1;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      y1_q      <= '0;
      x1_q      <= '0;
      y1_vld_q  <= 1'b0;
      x1_vld_q  <= 1'b0;
      cnt_q     <= '0;
      id_q      <= '0;
      flush_q   <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y1_q      <= y1_d;
      x1_q      <= x1_d;
      y1_vld_q  <= y1_vld_d;
      x1_vld_q  <= x1_vld_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      flush_q   <= flush_d;
      clamped_q <= clamped_d;
    end
  end

  assign up_pix_TREADY  = flt_pix_TREADY && in_run;
  assign flt_pix_TVALID = up_pix_TVALID && in_run;
  assign crop_Y1_TDATA  = y1_q;
  assign crop_Y1_TVALID = y1_vld_q;
  assign crop_X1_TDATA  = x1_q;
  assign crop_X1_TVALID = x1_vld_q;
  assign flt_reset      = reset || flush_q;
  assign frame_done     = flush_q;
  assign frame_req_id   = id_q;
  assign roi_clamped    = clamped_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_crop_roi_sequencer.sv
// Randomized frame-level bench for crop_roi_sequencer against a transaction-level model.
module tb_crop_roi_sequencer;
  import crop_ctl_pkg::*;

  localparam int N     = 2;
  localparam int IR    = 40;
  localparam int IC    = 40;
  localparam int OROWS = 20;
  localparam int OCOLS = 20;
  localparam int DW    = RW + CW;

  logic                clk;
  logic                reset;
  logic [N*DW-1:0]     req_roi_TDATA;
  logic [N-1:0]        req_roi_TVALID;
  logic [N-1:0]        req_roi_TREADY;
  logic                up_pix_TVALID;
  logic                up_pix_TREADY;
  logic                flt_pix_TVALID;
  logic                flt_pix_TREADY;
  logic [RW-1:0]       crop_Y1_TDATA;
  logic                crop_Y1_TVALID;
  logic                crop_Y1_TREADY;
  logic [CW-1:0]       crop_X1_TDATA;
  logic                crop_X1_TVALID;
  logic                crop_X1_TREADY;
  logic                flt_reset;
  logic                frame_done;
  logic [REQ_ID_W-1:0] frame_req_id;
  logic                roi_clamped;
  logic                busy;

  crop_roi_sequencer #(
    .NUM_REQ(N), .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OROWS), .OUT_COLS(OCOLS),
    .IMG_ROW_BITWIDTH(RW), .IMG_COL_BITWIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_roi_TDATA(req_roi_TDATA), .req_roi_TVALID(req_roi_TVALID), .req_roi_TREADY(req_roi_TREADY),
    .up_pix_TVALID(up_pix_TVALID), .up_pix_TREADY(up_pix_TREADY),
    .flt_pix_TVALID(flt_pix_TVALID), .flt_pix_TREADY(flt_pix_TREADY),
    .crop_Y1_TDATA(crop_Y1_TDATA), .crop_Y1_TVALID(crop_Y1_TVALID), .crop_Y1_TREADY(crop_Y1_TREADY),
    .crop_X1_TDATA(crop_X1_TDATA), .crop_X1_TVALID(crop_X1_TVALID), .crop_X1_TREADY(crop_X1_TREADY),
    .flt_reset(flt_reset), .frame_done(frame_done), .frame_req_id(frame_req_id),
    .roi_clamped(roi_clamped), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int next_turn;
  bit pending [N];
  int req_y   [N];
  int req_x   [N];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester whose turn it is: first pending one starting from the one after the last winner.
  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      if (pending[(next_turn + k) % N]) return (next_turn + k) % N;
    end
    return -1;
  endfunction

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_roi_TVALID[i] = pending[i];
      req_roi_TDATA[i*DW +: DW] = {RW'(req_y[i]), CW'(req_x[i])};
    end
  endtask

  task automatic post_req(input int id, input int y, input int x);
    pending[id] = 1'b1;
    req_y[id]   = y;
    req_x[id]   = x;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive_reqs();
    repeat (2) tick();
    reset = 1'b0;
    next_turn = 0;
  endtask

  task automatic do_frame(input int ys, input int xs, input int stall_pct,
                          input int abort_at, input bit refill);
    int exp_id, ey, ex, cnt, k;
    bit seen, ecl, yd, xd, yhs, xhs, hs;
    exp_id = model_pick();
    seen = 1'b0;
    crop_Y1_TREADY = 1'b0;
    crop_X1_TREADY = 1'b0;
    for (k = 0; k < 20 && !seen; k++) begin
      drive_reqs();
      up_pix_TVALID  = 1'b1;
      flt_pix_TREADY = 1'b1;
      #1;
      if (req_roi_TREADY != '0) seen = 1'b1;
      else begin
        check_eq("idle_up_ready", up_pix_TREADY, 0);
        tick();
      end
    end
    if (!seen || exp_id < 0) begin
      check_eq("grant_timeout", 0, 1);
      return;
    end
    check_eq("grant_onehot", req_roi_TREADY, 1 << exp_id);
    check_eq("idle_up_ready", up_pix_TREADY, 0);
    check_eq("idle_flt_valid", flt_pix_TVALID, 0);
    ey  = clamp(req_y[exp_id], IR - OROWS);
    ex  = clamp(req_x[exp_id], IC - OCOLS - 1);
    ecl = (ey != req_y[exp_id]) || (ex != req_x[exp_id]);
    tick();
    next_turn = (exp_id + 1) % N;
    pending[exp_id] = 1'b0;
    if (refill) post_req(exp_id, $urandom_range(IR - OROWS), $urandom_range(IC - OCOLS - 1));
    check_eq("y1_valid_t1", crop_Y1_TVALID, 1);
    check_eq("x1_valid_t1", crop_X1_TVALID, 1);
    check_eq("y1_data", crop_Y1_TDATA, ey);
    check_eq("x1_data", crop_X1_TDATA, ex);
    check_eq("roi_clamped", roi_clamped, ecl);
    check_eq("frame_req_id", frame_req_id, exp_id);
    check_eq("busy_load", busy, 1);

    yd = 1'b0;
    xd = 1'b0;
    for (k = 0; k < 50 && !(yd && xd); k++) begin
      drive_reqs();
      crop_Y1_TREADY = (k >= ys);
      crop_X1_TREADY = (k >= xs);
      up_pix_TVALID  = 1'b1;
      flt_pix_TREADY = 1'b1;
      #1;
      check_eq("load_flt_valid", flt_pix_TVALID, 0);
      check_eq("load_up_ready", up_pix_TREADY, 0);
      check_eq("load_req_ready", req_roi_TREADY, 0);
      yhs = crop_Y1_TVALID && crop_Y1_TREADY;
      xhs = crop_X1_TVALID && crop_X1_TREADY;
      tick();
      if (yhs) yd = 1'b1;
      if (xhs) xd = 1'b1;
      check_eq("y1_valid", crop_Y1_TVALID, !yd);
      check_eq("x1_valid", crop_X1_TVALID, !xd);
      check_eq("clamp_pulse_len", roi_clamped, 0);
    end
    if (!(yd && xd)) begin
      check_eq("coord_timeout", 0, 1);
      return;
    end
    crop_Y1_TREADY = 1'b0;
    crop_X1_TREADY = 1'b0;

    cnt = 0;
    for (k = 0; k < 20000 && cnt < FRAME_PIX; k++) begin
      drive_reqs();
      up_pix_TVALID  = ($urandom_range(99) >= (stall_pct / 2));
      flt_pix_TREADY = ($urandom_range(99) >= stall_pct);
      #1;
      check_eq("run_flt_valid", flt_pix_TVALID, up_pix_TVALID);
      check_eq("run_up_ready", up_pix_TREADY, flt_pix_TREADY);
      check_eq("run_req_ready", req_roi_TREADY, 0);
      hs = up_pix_TVALID && up_pix_TREADY;
      tick();
      if (hs) cnt++;
      check_eq("frame_done", frame_done, cnt == FRAME_PIX);
      if (abort_at > 0 && cnt == abort_at) begin
        reset = 1'b1;
        #1;
        check_eq("rst_flt_reset", flt_reset, 1);
        check_eq("rst_up_ready", up_pix_TREADY, 0);
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_no_done", frame_done, 0);
        reset = 1'b0;
        next_turn = 0;
        drive_reqs();
        tick();
        check_eq("post_rst_flt_reset", flt_reset, 0);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_no_done", frame_done, 0);
        $display("[TB] frame req=%0d y1=%0d x1=%0d aborted after %0d pixels", exp_id, ey, ex, cnt);
        return;
      end
    end
    if (cnt < FRAME_PIX) begin
      check_eq("pixel_timeout", cnt, FRAME_PIX);
      return;
    end
    check_eq("flush_flt_reset", flt_reset, 1);
    check_eq("flush_busy", busy, 1);
    up_pix_TVALID  = 1'b1;
    flt_pix_TREADY = 1'b1;
    drive_reqs();
    #1;
    check_eq("flush_up_ready", up_pix_TREADY, 0);
    check_eq("flush_flt_valid", flt_pix_TVALID, 0);
    check_eq("flush_req_ready", req_roi_TREADY, 0);
    tick();
    check_eq("done_pulse_len", frame_done, 0);
    check_eq("flt_reset_len", flt_reset, 0);
    check_eq("idle_busy", busy, 0);
    $display("[TB] frame req=%0d y1=%0d x1=%0d clamped=%0d pixels=%0d", exp_id, ey, ex, ecl, cnt);
  endtask

  initial begin
    reset          = 1'b1;
    req_roi_TDATA  = '0;
    req_roi_TVALID = '0;
    up_pix_TVALID  = 1'b0;
    flt_pix_TREADY = 1'b0;
    crop_Y1_TREADY = 1'b0;
    crop_X1_TREADY = 1'b0;
    next_turn      = 0;
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b0;
      req_y[i]   = 0;
      req_x[i]   = 0;
    end
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flt_reset", flt_reset, 1);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_roi_clamped", roi_clamped, 0);
    check_eq("rst_y1_valid", crop_Y1_TVALID, 0);
    check_eq("rst_x1_valid", crop_X1_TVALID, 0);
    check_eq("rst_req_ready", req_roi_TREADY, 0);
    check_eq("rst_frame_req_id", frame_req_id, 0);
    check_eq("rst_up_ready", up_pix_TREADY, 0);

    // Basic frame from requester 0, continuous pixels.
    post_req(0, 5, 3);
    reset = 1'b0;
    do_frame(0, 0, 0, 0, 1'b0);

    // Both requesters valid at reset release; random filter stalls.
    post_req(0, $urandom_range(IR - OROWS), $urandom_range(IC - OCOLS - 1));
    post_req(1, $urandom_range(IR - OROWS), $urandom_range(IC - OCOLS - 1));
    apply_reset();
    do_frame(0, 0, 30, 0, 1'b1);
    do_frame(0, 0, 30, 0, 1'b1);
    do_frame(1, 0, 30, 0, 1'b0);
    do_frame(0, 2, 30, 0, 1'b0);

    // Out-of-range box clamps to the bottom-right corner.
    post_req(1, 30, 25);
    do_frame(0, 0, 0, 0, 1'b0);

    // Y1 accepted three cycles after X1.
    post_req(0, $urandom_range(IR - OROWS), $urandom_range(IC - OCOLS - 1));
    do_frame(3, 0, 10, 0, 1'b0);

    // Reset halfway through a frame, then a clean frame.
    post_req(1, $urandom_range(IR - OROWS), $urandom_range(IC - OCOLS - 1));
    do_frame(0, 0, 0, 800, 1'b0);
    post_req(0, $urandom_range(IR - OROWS), $urandom_range(IC - OCOLS - 1));
    do_frame(1, 1, 20, 0, 1'b0);

    // Random requesters with full-range coordinates.
    for (int f = 0; f < 3; f++) begin
      post_req($urandom_range(N - 1), $urandom_range(1023), $urandom_range(1023));
      do_frame($urandom_range(3), $urandom_range(3), 20, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
